// File: rtl/uart_debug_bus_master_if.sv
// Signal bundle for the UART debug bus master: UART RX/TX handshake, the CPU-side
// bus request and the arbitrated memory bus.
interface uart_debug_bus_master_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_active;
  logic        tx_done;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic        cpu_halt;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;

  modport master (
    input  rx_valid, rx_data, tx_active, tx_done,
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_rdata,
    output tx_start, tx_data, cpu_halt, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport slave (
    output rx_valid, rx_data, tx_active, tx_done,
    output cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_rdata,
    input  tx_start, tx_data, cpu_halt, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/uart_debug_bus_master.sv
// UART command sequencer: halts/resumes the CPU, and while halted owns the memory
// bus to perform single-byte debug writes and reads (read data returned over UART).
module uart_debug_bus_master #(
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 2_000_000
) (
  input logic                    clk,
  input logic                    rst,
  uart_debug_bus_master_if.master bus
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, GET_AH, GET_AL, GET_D, BUS_WR, BUS_RD, RD_WAIT, TX_GO, TX_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic              is_rd_q, is_rd_d;
  logic [15:0]       addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              halt_q, halt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [3:0]        lat_q, lat_d;
  logic              tx_start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      is_rd_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx_data_q <= '0;
      halt_q    <= 1'b0;
      to_cnt_q  <= '0;
      lat_q     <= '0;
    end else begin
      state_q   <= state_d;
      is_rd_q   <= is_rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tx_data_q <= tx_data_d;
      halt_q    <= halt_d;
      to_cnt_q  <= to_cnt_d;
      lat_q     <= lat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    is_rd_d   = is_rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tx_data_d = tx_data_q;
    halt_d    = halt_q;
    to_cnt_d  = '0;
    lat_d     = lat_q;
    tx_start  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.rx_valid) begin
          case (bus.rx_data)
            8'h00: halt_d = 1'b1;
            8'h01: halt_d = 1'b0;
            8'h02: begin is_rd_d = 1'b0; state_d = GET_AH; end
            8'h03: begin is_rd_d = 1'b1; state_d = GET_AH; end
            default: ;
          endcase
        end
      end
      GET_AH, GET_AL, GET_D: begin
        // A byte arriving on the timeout cycle still counts and restarts the window.
        if (bus.rx_valid) begin
          case (state_q)
            GET_AH: begin addr_d[15:8] = bus.rx_data; state_d = GET_AL; end
            GET_AL: begin
              addr_d[7:0] = bus.rx_data;
              state_d     = is_rd_q ? BUS_RD : GET_D;
            end
            default: begin wdata_d = bus.rx_data; state_d = BUS_WR; end
          endcase
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      BUS_WR: state_d = IDLE;
      BUS_RD: begin
        lat_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_q == 4'(RD_LAT - 1)) begin
          // A read issued while the CPU owns the bus never reached memory.
          tx_data_d = halt_q ? bus.mem_rdata : 8'h00;
          state_d   = TX_GO;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      TX_GO: begin
        if (!bus.tx_active) begin
          tx_start = 1'b1;
          state_d  = TX_WAIT;
        end
      end
      TX_WAIT: if (bus.tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus ownership follows the registered halt flag, which only moves in IDLE.
  always_comb begin
    if (halt_q) begin
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      bus.mem_we    = (state_q == BUS_WR);
      bus.mem_re    = (state_q == BUS_RD);
    end else begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      bus.mem_we    = bus.cpu_we;
      bus.mem_re    = bus.cpu_re;
    end
  end

  assign bus.cpu_halt = halt_q;
  assign bus.tx_start = tx_start;
  assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_debug_bus_master.sv
// Directed bench for uart_debug_bus_master: halt, debug write/read, CPU passthrough,
// inter-byte timeout and asynchronous reset during a reply.
module tb_uart_debug_bus_master;
  localparam int RD_LAT  = 2;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_debug_bus_master_if ifc ();

  uart_debug_bus_master #(.RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: read data appears exactly RD_LAT cycles after the mem_re cycle.
  logic [7:0]        rd_val = 8'h00;
  logic [RD_LAT-1:0] re_pipe = '0;
  always @(posedge clk) re_pipe <= {re_pipe[RD_LAT-2:0], ifc.mem_re};
  assign ifc.mem_rdata = re_pipe[RD_LAT-1] ? rd_val : 8'h00;

  // Bus and UART monitors: cycle counts of strobes plus last-seen payloads.
  int          we_cnt = 0, re_cnt = 0, tx_cnt = 0;
  logic [15:0] we_addr = '0, re_addr = '0;
  logic [7:0]  we_data = '0, tx_seen = '0;
  always @(posedge clk) begin
    if (ifc.mem_we) begin we_cnt <= we_cnt + 1; we_addr <= ifc.mem_addr; we_data <= ifc.mem_wdata; end
    if (ifc.mem_re) begin re_cnt <= re_cnt + 1; re_addr <= ifc.mem_addr; end
    if (ifc.tx_start) begin tx_cnt <= tx_cnt + 1; tx_seen <= ifc.tx_data; end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = b;
    @(negedge clk);
    ifc.rx_valid = 1'b0;
    ifc.rx_data  = 8'h00;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a); send_byte(b); send_byte(c);
  endtask

  task automatic wait_tx(input string tag, input int base);
    for (int i = 0; i < 100 && tx_cnt == base; i++) @(negedge clk);
    check(tag, 32'(tx_cnt - base), 32'd1);
  endtask

  task automatic pulse_tx_done();
    @(negedge clk); ifc.tx_done = 1'b1;
    @(negedge clk); ifc.tx_done = 1'b0;
  endtask

  int we0, re0, tx0;

  initial begin
    ifc.rx_valid  = 1'b0; ifc.rx_data  = 8'h00;
    ifc.tx_active = 1'b0; ifc.tx_done  = 1'b0;
    ifc.cpu_addr  = 16'h1234; ifc.cpu_wdata = 8'h00;
    ifc.cpu_we    = 1'b0; ifc.cpu_re   = 1'b0;
    cycles(3);
    check("rst_halt", 32'(ifc.cpu_halt), 32'd0);
    check("rst_txs", 32'(ifc.tx_start), 32'd0);
    check("rst_txd", 32'(ifc.tx_data), 32'h00);
    rst = 1'b1;
    cycles(2);
    check("pass_addr", 32'(ifc.mem_addr), 32'h1234);

    // T1 halt
    send_byte(8'h00);
    check("t1_halt", 32'(ifc.cpu_halt), 32'd1);
    check("t1_addr", 32'(ifc.mem_addr), 32'h0000);
    ifc.cpu_we = 1'b1; ifc.cpu_re = 1'b1; #1;
    check("t1_we_blk", 32'(ifc.mem_we), 32'd0);
    check("t1_re_blk", 32'(ifc.mem_re), 32'd0);
    ifc.cpu_we = 1'b0; ifc.cpu_re = 1'b0;

    // T2 debug write
    we0 = we_cnt; re0 = re_cnt;
    send_byte(8'h02); send3(8'h20, 8'h06, 8'h3F);
    cycles(4);
    check("t2_we_n", 32'(we_cnt - we0), 32'd1);
    check("t2_addr", 32'(we_addr), 32'h2006);
    check("t2_data", 32'(we_data), 32'h3F);
    check("t2_re_n", 32'(re_cnt - re0), 32'd0);

    // T3 debug read, UART busy at first
    rd_val = 8'hA5; ifc.tx_active = 1'b1;
    re0 = re_cnt; tx0 = tx_cnt;
    send3(8'h03, 8'h20, 8'h07);
    cycles(10);
    check("t3_tx_held", 32'(tx_cnt - tx0), 32'd0);
    ifc.tx_active = 1'b0;
    wait_tx("t3_tx_n", tx0);
    check("t3_re_n", 32'(re_cnt - re0), 32'd1);
    check("t3_re_addr", 32'(re_addr), 32'h2007);
    check("t3_tx_data", 32'(tx_seen), 32'hA5);
    cycles(3);
    check("t3_tx_once", 32'(tx_cnt - tx0), 32'd1);
    check("t3_txd_hold", 32'(ifc.tx_data), 32'hA5);
    pulse_tx_done();
    send_byte(8'h01);
    check("t3_resume", 32'(ifc.cpu_halt), 32'd0);

    // T4 not halted: debug frames do not reach the bus
    we0 = we_cnt; re0 = re_cnt; tx0 = tx_cnt;
    send_byte(8'h02); send3(8'h00, 8'h10, 8'h55);
    cycles(4);
    check("t4_we_n", 32'(we_cnt - we0), 32'd0);
    ifc.cpu_we = 1'b1; ifc.cpu_wdata = 8'h77; #1;
    check("t4_cpu_we", 32'(ifc.mem_we), 32'd1);
    check("t4_cpu_wd", 32'(ifc.mem_wdata), 32'h77);
    check("t4_cpu_ad", 32'(ifc.mem_addr), 32'h1234);
    @(negedge clk); ifc.cpu_we = 1'b0;
    re0 = re_cnt;
    send3(8'h03, 8'h00, 8'h10);
    wait_tx("t4_tx_n", tx0);
    check("t4_reply", 32'(tx_seen), 32'h00);
    check("t4_re_n", 32'(re_cnt - re0), 32'd0);
    pulse_tx_done();

    // T5 timeout mid-frame, next frame parsed cleanly
    send_byte(8'h00);
    rd_val = 8'h5A;
    we0 = we_cnt; re0 = re_cnt; tx0 = tx_cnt;
    send_byte(8'h02); send_byte(8'h20);
    cycles(TIMEOUT + 1);
    send3(8'h03, 8'h20, 8'h02);
    wait_tx("t5_tx_n", tx0);
    check("t5_we_n", 32'(we_cnt - we0), 32'd0);
    check("t5_re_n", 32'(re_cnt - re0), 32'd1);
    check("t5_re_addr", 32'(re_addr), 32'h2002);
    check("t5_reply", 32'(tx_seen), 32'h5A);
    pulse_tx_done();

    // T6 reset during TX_WAIT
    tx0 = tx_cnt;
    send3(8'h03, 8'h20, 8'h07);
    wait_tx("t6_tx_n", tx0);
    @(negedge clk);
    rst = 1'b0; #1;
    check("t6_txs", 32'(ifc.tx_start), 32'd0);
    check("t6_halt", 32'(ifc.cpu_halt), 32'd0);
    check("t6_txd", 32'(ifc.tx_data), 32'h00);
    @(negedge clk); rst = 1'b1;
    tx0 = tx_cnt;
    send_byte(8'h01);
    cycles(10);
    check("t6_no_tx", 32'(tx_cnt - tx0), 32'd0);
    check("t6_halt2", 32'(ifc.cpu_halt), 32'd0);
    check("t6_pass", 32'(ifc.mem_addr), 32'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
